// File: rtl/p405s_sportincseq_pkg.sv
// Shared types and constants for the S-port incrementing read sequencer.
// Optional feature macro used by the top: P405S_SPORT_SEQ_PERF_EN.
package p405s_sPortSeq_pkg;

    localparam int GPR_AW = 5;
    localparam int CNT_W  = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seqState_t;

    // A register count of 0 encodes a full 32-register transfer.
    function automatic logic [0:CNT_W-1] normRegCnt(input logic [0:CNT_W-1] regCnt);
        return (regCnt == '0) ? CNT_W'(32) : regCnt;
    endfunction

endpackage

// File: rtl/p405s_sportincseq_addrcmp.sv
// 5-bit GPR address equality compare, qualified by a valid and an enable.
module p405s_sPortAddrCmp
    import p405s_sPortSeq_pkg::*;
(
    input  logic              enable,
    input  logic [0:GPR_AW-1] addrA,
    input  logic [0:GPR_AW-1] addrB,
    input  logic              addrVld,
    output logic              eq
);

    assign eq = enable & addrVld & (addrA == addrB);

endmodule

// File: rtl/p405s_sportincseq.sv
// S-port read-address sequencer for load/store-multiple and string stores.
// Define P405S_SPORT_SEQ_PERF_EN to add the saturating seqStallCnt output.
module p405s_sportincseq
    import p405s_sPortSeq_pkg::*;
(
    input  logic              CB,
    input  logic              resetN,
    input  logic              dcdStart,
    input  logic [0:GPR_AW-1] dcdSpAddr,
    input  logic [0:CNT_W-1]  dcdRegCnt,
    input  logic              dcdHold,
    input  logic              exeHold,
    input  logic              exeFlush,
    input  logic [0:GPR_AW-1] wbRpAddr,
    input  logic              wbRpVld,
    input  logic [0:GPR_AW-1] lwbLpAddr,
    input  logic              lwbLpVld,
    output logic [0:GPR_AW-1] exeRS,
    output logic [0:2*GPR_AW-1] preExeRS,
    output logic              exeRSEqwbRpAddr,
    output logic              exeRSEqlwbLpAddr,
    output logic              sPortSelInc,
    output logic              seqBusy,
    output logic              seqLast
`ifdef P405S_SPORT_SEQ_PERF_EN
    ,
    output logic [0:15]       seqStallCnt
`endif
);

    seqState_t         stateReg, stateNext;
    logic [0:GPR_AW-1] exeRSReg, exeRSNext;
    logic [0:CNT_W-1]  remCntReg, remCntNext;
    logic [0:CNT_W-1]  startCnt;
    logic              runActive;

    assign startCnt  = normRegCnt(dcdRegCnt);
    assign runActive = (stateReg == RUN);

    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            stateReg  <= IDLE;
            exeRSReg  <= '0;
            remCntReg <= '0;
        end else begin
            stateReg  <= stateNext;
            exeRSReg  <= exeRSNext;
            remCntReg <= remCntNext;
        end
    end

    // Flush wins over everything; a single-register op is fully served in decode.
    always_comb begin
        stateNext  = stateReg;
        exeRSNext  = exeRSReg;
        remCntNext = remCntReg;
        if (exeFlush) begin
            stateNext  = IDLE;
            remCntNext = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (dcdStart && !dcdHold && (startCnt > CNT_W'(1))) begin
                        stateNext  = RUN;
                        exeRSNext  = dcdSpAddr + GPR_AW'(1);
                        remCntNext = startCnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!exeHold) begin
                        if (remCntReg == CNT_W'(1)) begin
                            stateNext  = IDLE;
                            remCntNext = '0;
                        end else begin
                            exeRSNext  = exeRSReg + GPR_AW'(1);
                            remCntNext = remCntReg - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    remCntNext = '0;
                end
            endcase
        end
    end

    assign exeRS       = exeRSReg;
    assign preExeRS    = {exeRSReg, ~exeRSReg};
    assign sPortSelInc = runActive;
    assign seqBusy     = runActive;
    assign seqLast     = runActive & (remCntReg == CNT_W'(1));

    // Hazard compares against the two write-back ports.
    logic [0:GPR_AW-1] cmpAddr [0:1];
    logic              cmpVld  [0:1];
    logic              cmpEq   [0:1];

    assign cmpAddr[0] = wbRpAddr;
    assign cmpVld[0]  = wbRpVld;
    assign cmpAddr[1] = lwbLpAddr;
    assign cmpVld[1]  = lwbLpVld;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gCmp
            p405s_sPortAddrCmp uCmp (
                .enable  (runActive),
                .addrA   (exeRSReg),
                .addrB   (cmpAddr[gi]),
                .addrVld (cmpVld[gi]),
                .eq      (cmpEq[gi])
            );
        end
    endgenerate

    assign exeRSEqwbRpAddr  = cmpEq[0];
    assign exeRSEqlwbLpAddr = cmpEq[1];

`ifdef P405S_SPORT_SEQ_PERF_EN
    logic [0:15] stallCntReg;

    always_ff @(posedge CB or negedge resetN) begin
        if (!resetN) begin
            stallCntReg <= '0;
        end else if (runActive && exeHold && (stallCntReg != 16'hFFFF)) begin
            stallCntReg <= stallCntReg + 16'd1;
        end
    end

    assign seqStallCnt = stallCntReg;
`endif

endmodule

// File: tb/tb_p405s_sportincseq.sv
// Directed bench for p405s_sportincseq with a scoreboard of expected exeRS reads.
module tb_p405s_sportincseq;

    logic       CB = 1'b0;
    logic       resetN;
    logic       dcdStart;
    logic [0:4] dcdSpAddr;
    logic [0:5] dcdRegCnt;
    logic       dcdHold;
    logic       exeHold;
    logic       exeFlush;
    logic [0:4] wbRpAddr;
    logic       wbRpVld;
    logic [0:4] lwbLpAddr;
    logic       lwbLpVld;
    logic [0:4] exeRS;
    logic [0:9] preExeRS;
    logic       exeRSEqwbRpAddr;
    logic       exeRSEqlwbLpAddr;
    logic       sPortSelInc;
    logic       seqBusy;
    logic       seqLast;
`ifdef P405S_SPORT_SEQ_PERF_EN
    logic [0:15] seqStallCnt;
`endif

    int checks   = 0;
    int failures = 0;
    int expStall = 0;

    // Each entry: {last, rs} for one expected execute-side read.
    logic [5:0] sb[$];

    always #5 CB = ~CB;

    p405s_sportincseq dut (
        .CB               (CB),
        .resetN           (resetN),
        .dcdStart         (dcdStart),
        .dcdSpAddr        (dcdSpAddr),
        .dcdRegCnt        (dcdRegCnt),
        .dcdHold          (dcdHold),
        .exeHold          (exeHold),
        .exeFlush         (exeFlush),
        .wbRpAddr         (wbRpAddr),
        .wbRpVld          (wbRpVld),
        .lwbLpAddr        (lwbLpAddr),
        .lwbLpVld         (lwbLpVld),
        .exeRS            (exeRS),
        .preExeRS         (preExeRS),
        .exeRSEqwbRpAddr  (exeRSEqwbRpAddr),
        .exeRSEqlwbLpAddr (exeRSEqlwbLpAddr),
        .sPortSelInc      (sPortSelInc),
        .seqBusy          (seqBusy),
        .seqLast          (seqLast)
`ifdef P405S_SPORT_SEQ_PERF_EN
        ,
        .seqStallCnt      (seqStallCnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_exeRS"}, 32'(exeRS), 32'h0);
        chk({tag, "_preExeRS"}, 32'(preExeRS), 32'h01F);
        chk({tag, "_wbEq"}, 32'(exeRSEqwbRpAddr), 32'h0);
        chk({tag, "_lwbEq"}, 32'(exeRSEqlwbLpAddr), 32'h0);
        chk({tag, "_selInc"}, 32'(sPortSelInc), 32'h0);
        chk({tag, "_busy"}, 32'(seqBusy), 32'h0);
        chk({tag, "_last"}, 32'(seqLast), 32'h0);
    endtask

    // Called at posedge+1 with inputs set; checks, updates the model, advances one clock.
    task automatic cycle();
        logic       busy;
        logic [5:0] e;
        int         n;
        e = '0;
        #1;
        busy = (sb.size() != 0);
        if (busy) e = sb[0];
        chk("seqBusy", 32'(seqBusy), 32'(busy));
        chk("sPortSelInc", 32'(sPortSelInc), 32'(busy));
        if (busy) begin
            chk("exeRS", 32'(exeRS), 32'(e[4:0]));
            chk("seqLast", 32'(seqLast), 32'(e[5]));
            chk("preExeRS", 32'(preExeRS), 32'({e[4:0], ~e[4:0]}));
        end else begin
            chk("seqLastIdle", 32'(seqLast), 32'h0);
        end
        chk("wbEq", 32'(exeRSEqwbRpAddr), 32'(busy & wbRpVld & (e[4:0] == wbRpAddr)));
        chk("lwbEq", 32'(exeRSEqlwbLpAddr), 32'(busy & lwbLpVld & (e[4:0] == lwbLpAddr)));
        if (dcdStart && busy && !exeFlush) begin
            checks++;
            failures++;
            $error("FAIL protocol dcdStart observed=1 expected=0 while busy");
        end
        if (busy && exeHold) expStall++;
        $display("cyc t=%0t start=%0b hold=%0b flush=%0b busy=%0b exeRS=%0d last=%0b pending=%0d",
                 $time, dcdStart, exeHold, exeFlush, seqBusy, exeRS, seqLast, sb.size());
        if (exeFlush) begin
            sb.delete();
        end else if (busy) begin
            if (!exeHold) void'(sb.pop_front());
        end else if (dcdStart && !dcdHold) begin
            n = (dcdRegCnt == 0) ? 32 : int'(dcdRegCnt);
            for (int k = 1; k < n; k++)
                sb.push_back({(k == n - 1) ? 1'b1 : 1'b0, 5'((int'(dcdSpAddr) + k) % 32)});
        end
        @(posedge CB);
        #1;
    endtask

    task automatic startSeq(input logic [0:4] rs, input logic [0:5] cnt);
        dcdStart  = 1'b1;
        dcdSpAddr = rs;
        dcdRegCnt = cnt;
        cycle();
        dcdStart  = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; dcdStart = 1'b0; dcdSpAddr = '0; dcdRegCnt = '0;
        dcdHold = 1'b0; exeHold = 1'b0; exeFlush = 1'b0;
        wbRpAddr = '0; wbRpVld = 1'b0; lwbLpAddr = '0; lwbLpVld = 1'b0;
        #2;
        chkResetOutputs("por");
        @(posedge CB); #1;
        resetN = 1'b1;
        repeat (2) cycle();

        // stmw r27, 5 registers, no stalls
        startSeq(5'd27, 6'd5);
        repeat (5) cycle();

        // stswi r30, 4 registers, stalled in RUN cycles 2-3, wraps 31->0
        startSeq(5'd30, 6'd4);
        exeHold = 1'b0; cycle();
        exeHold = 1'b1; cycle();
        exeHold = 1'b1; cycle();
        exeHold = 1'b0; cycle();
        cycle();
        cycle();

        // single-register op and held decode never enter RUN
        startSeq(5'd5, 6'd1);
        repeat (2) cycle();
        dcdHold = 1'b1;
        startSeq(5'd9, 6'd4);
        dcdHold = 1'b0;
        repeat (2) cycle();

        // regCnt 0 from r0: 31 reads r1..r31
        startSeq(5'd0, 6'd0);
        repeat (32) cycle();

        // flush with concurrent hold and start aborts; restart after IDLE
        startSeq(5'd10, 6'd6);
        cycle();
        exeFlush = 1'b1; exeHold = 1'b1; dcdStart = 1'b1; dcdSpAddr = 5'd3; dcdRegCnt = 6'd2;
        cycle();
        exeFlush = 1'b0; exeHold = 1'b0; dcdStart = 1'b0;
        cycle();
        startSeq(5'd3, 6'd3);
        repeat (3) cycle();

        // write-back hazard compares at exeRS=12
        startSeq(5'd11, 6'd3);
        wbRpAddr = 5'd12; wbRpVld = 1'b1; lwbLpAddr = 5'd12; lwbLpVld = 1'b0; exeHold = 1'b1;
        #1;
        chk("t6_wbEq", 32'(exeRSEqwbRpAddr), 32'h1);
        chk("t6_lwbEq", 32'(exeRSEqlwbLpAddr), 32'h0);
        cycle();
        lwbLpVld = 1'b1;
        cycle();
        exeHold = 1'b0; lwbLpVld = 1'b0;
        repeat (3) cycle();
        chk("t6_idleWbEq", 32'(exeRSEqwbRpAddr), 32'h0);

`ifdef P405S_SPORT_SEQ_PERF_EN
        chk("stallCnt", 32'(seqStallCnt), 32'(expStall));
`endif

        // asynchronous reset while RUN with remCnt=5
        startSeq(5'd20, 6'd7);
        cycle();
        #2;
        resetN = 1'b0;
        #1;
        chkResetOutputs("midrun");
        sb.delete();
        expStall = 0;
        @(posedge CB); #1;
        chkResetOutputs("inrst");
        resetN = 1'b1;
        repeat (3) cycle();
`ifdef P405S_SPORT_SEQ_PERF_EN
        chk("stallCntRst", 32'(seqStallCnt), 32'(expStall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
